memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares one single-ported unified instruction/data RAM between the instruction-fetch stage and the memory-access stage of the 5-stage pipeline. Serialises requests through a fixed-latency RAM, returns read data to the winner and drives the stall signals that gate `pcWrite`/`ifIdWrite` and freeze the later stages. Sits between the two stages and the RAM. Replaces their private memories.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `MEM_LATENCY`, 2: cycles from the RAM sampling `ramEnable` to `ramReadData` being valid. Must be ≥1.
- `STARVE_LIMIT`, 4: maximum consecutive memory-stage wins while `ifReq` is pending.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `ifReq`  in  1  fetch request; held until `ifGrant`.
- `ifAddr`  in  ADDR_WIDTH  fetch address.
- `ifGrant`  out  1  one-cycle pulse: `ifData` is valid.
- `ifData`  out  DATA_WIDTH  fetched instruction.
- `memReq`  in  1  load/store request; held until `memDone`.
- `memWrite`  in  1  1 = store.
- `memAddr`  in  ADDR_WIDTH  data address.
- `memWriteData`  in  DATA_WIDTH  store data.
- `memDone`  out  1  one-cycle completion pulse.
- `memReadData`  out  DATA_WIDTH  load data.
- `ramEnable`, `ramWrite`  out  1  RAM strobe and write enable.
- `ramAddr`  out  ADDR_WIDTH; `ramWriteData`  out  DATA_WIDTH  RAM command.
- `ramReadData`  in  DATA_WIDTH  RAM read data.
- `fetchStall`  out  1  `ifReq & ~ifGrant`. Combinational.
- `memStall`  out  1  `memReq & ~memDone`. Combinational.

## Operation
- The FSM has four states.
  - IDLE: arbitrate. Go to ISSUE if any request is present.
  - ISSUE: one cycle. Drive the RAM command.
  - WAIT: count `MEM_LATENCY` cycles.
  - DONE: one cycle. Pulse `ifGrant` or `memDone`. Always returns to IDLE.
- Requests present in DONE are ignored. The finishing requester's `req` is still high in that cycle and must not be re-granted.
- Arbitration in IDLE:
  - `memReq` wins over `ifReq` (older instruction first).
  - Exception: `ifReq` wins if `starveCount == STARVE_LIMIT`.
- The winner's address, write flag and data are latched into command registers on the IDLE→ISSUE edge. The owner is latched in a 1-bit `owner` register.
- `starveCount` behaviour:
  - Increments, saturating at `STARVE_LIMIT`, when the memory stage is granted while `ifReq = 1`.
  - Clears when the fetch stage is granted.
- RAM command outputs (`ramEnable`, `ramWrite`, `ramAddr`, `ramWriteData`) are registered. They are non-zero only in ISSUE and are 0 in every other state.
- Reads: `ramReadData` is captured in the last WAIT cycle into `ifData` or `memReadData` according to `owner`. The other data output holds its value.
- Stores use the same latency. `memDone` pulses in DONE and `memReadData` is unchanged.
- A requester that drops `req` before completion is a protocol violation. The transaction still completes and pulses done.
- Data outputs hold their last value until the next capture.
- Reset values: state IDLE, `starveCount` 0, `owner` 0, and all outputs 0 including `ifData` and `memReadData`.
- Reset during ISSUE or WAIT: the transaction is aborted and no done pulse is produced. A late RAM response is ignored.

## Timing
- Request seen in IDLE at cycle 0:
  - `ramEnable` = 1 in cycle 1.
  - Data captured at the end of cycle 1+`MEM_LATENCY`.
  - Done pulse in cycle 2+`MEM_LATENCY`.
- Total per transaction: `MEM_LATENCY`+3 cycles, including the IDLE arbitration cycle. With `MEM_LATENCY` = 2 this is 5 cycles.
- A pending request is sampled in the first IDLE cycle after DONE. Back-to-back transactions are therefore spaced `MEM_LATENCY`+3 cycles apart.
- The stall outputs are combinational from `req` and the done pulses, with no added latency.

## Structure
- `microprocessor_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, DONE);
  - the owner encoding (`OWNER_IF` = 0, `OWNER_MEM` = 1);
  - the default `MEM_LATENCY` and `STARVE_LIMIT` constants.
- Sub-module `latency_counter`: loadable down-counter that asserts `expired` on its final count. It is used for WAIT.
- Arbitration, the starvation counter and the command registers stay in `memory_port_arbiter`.

## Test plan
All scenarios use `MEM_LATENCY` = 2 and `STARVE_LIMIT` = 4.
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs read 0 immediately, and state is IDLE.
- **Single fetch:** `ifReq` = 1, `ifAddr` = 0x10 in cycle 0; RAM returns 0x8C220004 → `ramEnable` = 1 with `ramAddr` = 0x10 in cycle 1; `ifGrant` = 1 with `ifData` = 0x8C220004 in cycle 4; `fetchStall` = 1 in cycles 0–3.
- **Contention:** `ifReq` and `memReq` (load 0x40) rise together → `memDone` in cycle 4; IF is issued in cycle 6; `ifGrant` in cycle 9.
- **Starvation:** `memReq` re-asserted immediately after each `memDone`, with `ifReq` held → exactly 4 memory grants, then `ifGrant`, then `starveCount` = 0.
- **Store:** `memWrite` = 1, `memAddr` = 0x80, `memWriteData` = 0xDEADBEEF → `ramWrite` = 1 for cycle 1 only; `memDone` in cycle 4; `memReadData` unchanged.
- **Reset mid-WAIT:** assert `reset` in cycle 2 of a fetch → no `ifGrant`; after release, a new fetch completes in 5 cycles with correct data.

Source files
------------

// File: rtl/microprocessor_pkg.sv
// Shared types and default constants for the unified instruction/data memory port.
package microprocessor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    localparam int DEFAULT_MEM_LATENCY  = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter; expired is high while enabled on the final count.
module latency_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = i_enable && (r_count == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and memory-stage access to one single-ported RAM with a
// fixed read latency; memory stage has priority, bounded by a starvation limit.
module memory_port_arbiter
    import microprocessor_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifGrant,
    output logic [DATA_WIDTH-1:0] ifData,
    input  logic                  memReq,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memDone,
    output logic [DATA_WIDTH-1:0] memReadData,
    output logic                  ramEnable,
    output logic                  ramWrite,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [DATA_WIDTH-1:0] ramWriteData,
    input  logic [DATA_WIDTH-1:0] ramReadData,
    output logic                  fetchStall,
    output logic                  memStall
);

    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          r_state;
    logic                r_owner;
    logic                r_cmd_write;
    logic [STARVE_W-1:0] r_starve_count;

    logic w_starved;
    logic w_grant_mem;
    logic w_expired;

    assign w_starved   = (r_starve_count == STARVE_W'(STARVE_LIMIT));
    assign w_grant_mem = memReq && !(ifReq && w_starved);

    // WAIT lasts exactly MEM_LATENCY cycles: load in ISSUE, expire on count zero.
    latency_counter #(
        .WIDTH(CNT_W)
    ) u_latency_counter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (r_state == ISSUE),
        .i_load_value(CNT_W'(MEM_LATENCY - 1)),
        .i_enable    (r_state == WAIT),
        .o_expired   (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_owner        <= OWNER_IF;
            r_cmd_write    <= 1'b0;
            r_starve_count <= '0;
            ifGrant        <= 1'b0;
            ifData         <= '0;
            memDone        <= 1'b0;
            memReadData    <= '0;
            ramEnable      <= 1'b0;
            ramWrite       <= 1'b0;
            ramAddr        <= '0;
            ramWriteData   <= '0;
        end else begin
            ifGrant <= 1'b0;
            memDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (memReq || ifReq) begin
                        r_state   <= ISSUE;
                        ramEnable <= 1'b1;
                        if (w_grant_mem) begin
                            r_owner      <= OWNER_MEM;
                            r_cmd_write  <= memWrite;
                            ramWrite     <= memWrite;
                            ramAddr      <= memAddr;
                            ramWriteData <= memWriteData;
                            if (ifReq && !w_starved) begin
                                r_starve_count <= r_starve_count + STARVE_W'(1);
                            end
                        end else begin
                            r_owner        <= OWNER_IF;
                            r_cmd_write    <= 1'b0;
                            ramWrite       <= 1'b0;
                            ramAddr        <= ifAddr;
                            ramWriteData   <= '0;
                            r_starve_count <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_state      <= WAIT;
                    ramEnable    <= 1'b0;
                    ramWrite     <= 1'b0;
                    ramAddr      <= '0;
                    ramWriteData <= '0;
                end
                WAIT: begin
                    if (w_expired) begin
                        r_state <= DONE;
                        if (r_owner == OWNER_IF) begin
                            ifGrant <= 1'b1;
                            ifData  <= ramReadData;
                        end else begin
                            memDone <= 1'b1;
                            if (!r_cmd_write) begin
                                memReadData <= ramReadData;
                            end
                        end
                    end
                end
                DONE: begin
                    // Requests still high here belong to the finishing transaction.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fetchStall = ifReq && !ifGrant;
    assign memStall   = memReq && !memDone;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a two-stage registered RAM model.
module tb_memory_port_arbiter;
    import microprocessor_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = '0;
    logic        ifGrant;
    logic [31:0] ifData;
    logic        memReq = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memWriteData = '0;
    logic        memDone;
    logic [31:0] memReadData;
    logic        ramEnable;
    logic        ramWrite;
    logic [31:0] ramAddr;
    logic [31:0] ramWriteData;
    logic [31:0] ramReadData;
    logic        fetchStall;
    logic        memStall;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [0:63];
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;

    always #5 clk = ~clk;

    // RAM model: read data valid two cycles after the enable is sampled
    always @(posedge clk) begin
        if (ramEnable && ramWrite) mem[ramAddr[7:2]] <= ramWriteData;
        rd1 <= (ramEnable && !ramWrite) ? mem[ramAddr[7:2]] : 32'h0;
        rd2 <= rd1;
    end
    assign ramReadData = rd2;

    memory_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGrant(ifGrant), .ifData(ifData),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
        .memWriteData(memWriteData), .memDone(memDone), .memReadData(memReadData),
        .ramEnable(ramEnable), .ramWrite(ramWrite), .ramAddr(ramAddr),
        .ramWriteData(ramWriteData), .ramReadData(ramReadData),
        .fetchStall(fetchStall), .memStall(memStall)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state;
        #1;
        n_checks++;
        if ({ifGrant, ifData, memDone, memReadData, ramEnable, ramWrite, ramAddr, ramWriteData} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_outputs: got %h%h%h%h expected all zero", ifData, memReadData, ramAddr, ramWriteData);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state_fsm: got %0d expected %0d", dut.r_state, IDLE);
        end
    endtask

    task automatic test_single_fetch;
        ifReq = 1'b1;
        ifAddr = 32'h10;
        for (int c = 0; c <= 4; c++) begin
            #1;
            n_checks++;
            if (fetchStall !== (c < 4)) begin
                n_fail++;
                $display("FAIL fetch_stall c%0d: got %b expected %b", c, fetchStall, (c < 4));
            end
            n_checks++;
            if (ramEnable !== (c == 1)) begin
                n_fail++;
                $display("FAIL fetch_ram_enable c%0d: got %b expected %b", c, ramEnable, (c == 1));
            end
            n_checks++;
            if (ifGrant !== (c == 4)) begin
                n_fail++;
                $display("FAIL fetch_grant c%0d: got %b expected %b", c, ifGrant, (c == 4));
            end
            if (c == 1) begin
                n_checks++;
                if (ramAddr !== 32'h10) begin
                    n_fail++;
                    $display("FAIL fetch_ram_addr: got %h expected %h", ramAddr, 32'h10);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (ifData !== 32'h8C220004) begin
                    n_fail++;
                    $display("FAIL fetch_data: got %h expected %h", ifData, 32'h8C220004);
                end
            end
            next_cycle();
        end
        ifReq = 1'b0;
    endtask

    task automatic test_contention;
        memReq = 1'b1;
        memWrite = 1'b0;
        memAddr = 32'h40;
        ifReq = 1'b1;
        ifAddr = 32'h44;
        for (int c = 0; c <= 9; c++) begin
            if (c == 5) memReq = 1'b0;
            #1;
            n_checks++;
            if (memDone !== (c == 4)) begin
                n_fail++;
                $display("FAIL contention_mem_done c%0d: got %b expected %b", c, memDone, (c == 4));
            end
            n_checks++;
            if (ifGrant !== (c == 9)) begin
                n_fail++;
                $display("FAIL contention_if_grant c%0d: got %b expected %b", c, ifGrant, (c == 9));
            end
            n_checks++;
            if (ramEnable !== (c == 1 || c == 6)) begin
                n_fail++;
                $display("FAIL contention_ram_enable c%0d: got %b expected %b", c, ramEnable, (c == 1 || c == 6));
            end
            n_checks++;
            if (memStall !== (c < 4)) begin
                n_fail++;
                $display("FAIL contention_mem_stall c%0d: got %b expected %b", c, memStall, (c < 4));
            end
            if (c == 1 || c == 6) begin
                n_checks++;
                if (ramAddr !== ((c == 1) ? 32'h40 : 32'h44)) begin
                    n_fail++;
                    $display("FAIL contention_ram_addr c%0d: got %h expected %h", c, ramAddr, ((c == 1) ? 32'h40 : 32'h44));
                end
            end
            if (c == 4) begin
                n_checks++;
                if (memReadData !== 32'h11112222) begin
                    n_fail++;
                    $display("FAIL contention_mem_data: got %h expected %h", memReadData, 32'h11112222);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (ifData !== 32'h33334444) begin
                    n_fail++;
                    $display("FAIL contention_if_data: got %h expected %h", ifData, 32'h33334444);
                end
            end
            next_cycle();
        end
        ifReq = 1'b0;
    endtask

    task automatic test_starvation;
        int mem_wins;
        bit found;
        mem_wins = 0;
        found = 1'b0;
        memReq = 1'b1;
        memWrite = 1'b0;
        memAddr = 32'h40;
        ifReq = 1'b1;
        ifAddr = 32'h10;
        for (int c = 0; c < 60 && !found; c++) begin
            #1;
            if (memDone) mem_wins++;
            if (ifGrant) begin
                found = 1'b1;
                n_checks++;
                if (mem_wins != 4) begin
                    n_fail++;
                    $display("FAIL starve_mem_wins: got %0d expected %0d", mem_wins, 4);
                end
                n_checks++;
                if (c != 24) begin
                    n_fail++;
                    $display("FAIL starve_grant_cycle: got %0d expected %0d", c, 24);
                end
                n_checks++;
                if (dut.r_starve_count !== '0) begin
                    n_fail++;
                    $display("FAIL starve_count_clear: got %0d expected %0d", dut.r_starve_count, 0);
                end
                n_checks++;
                if (ifData !== 32'h8C220004) begin
                    n_fail++;
                    $display("FAIL starve_if_data: got %h expected %h", ifData, 32'h8C220004);
                end
            end
            next_cycle();
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL starve_timeout: got no ifGrant expected one within 60 cycles");
        end
        memReq = 1'b0;
        ifReq = 1'b0;
    endtask

    task automatic test_store;
        memReq = 1'b1;
        memWrite = 1'b1;
        memAddr = 32'h80;
        memWriteData = 32'hDEADBEEF;
        for (int c = 0; c <= 4; c++) begin
            #1;
            n_checks++;
            if ({ramEnable, ramWrite} !== ((c == 1) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL store_ram_strobe c%0d: got %b%b expected %b", c, ramEnable, ramWrite, ((c == 1) ? 2'b11 : 2'b00));
            end
            n_checks++;
            if (memDone !== (c == 4)) begin
                n_fail++;
                $display("FAIL store_mem_done c%0d: got %b expected %b", c, memDone, (c == 4));
            end
            if (c == 1) begin
                n_checks++;
                if (ramAddr !== 32'h80 || ramWriteData !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL store_command: got %h/%h expected %h/%h", ramAddr, ramWriteData, 32'h80, 32'hDEADBEEF);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (ramWriteData !== 32'h0) begin
                    n_fail++;
                    $display("FAIL store_wdata_idle: got %h expected %h", ramWriteData, 32'h0);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (memReadData !== 32'h11112222) begin
                    n_fail++;
                    $display("FAIL store_read_data_hold: got %h expected %h", memReadData, 32'h11112222);
                end
            end
            next_cycle();
        end
        memReq = 1'b0;
        memWrite = 1'b0;
        memWriteData = '0;
        n_checks++;
        if (mem[32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL store_ram_contents: got %h expected %h", mem[32], 32'hDEADBEEF);
        end
    endtask

    task automatic test_reset;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ifGrant, ifData, memDone, memReadData, ramEnable, ramWrite, ramAddr, ramWriteData, fetchStall, memStall} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got if=%h mem=%h expected both 0", ifData, memReadData);
        end
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset_fsm: got %0d expected %0d", dut.r_state, IDLE);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        ifReq = 1'b1;
        ifAddr = 32'h10;
        next_cycle();
        next_cycle();
        #2;
        reset = 1'b1;
        ifReq = 1'b0;
        #1;
        n_checks++;
        if (dut.r_state !== IDLE || ramEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_abort: got state %0d en %b expected state %0d en 0", dut.r_state, ramEnable, IDLE);
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            #1;
            n_checks++;
            if (ifGrant !== 1'b0) begin
                n_fail++;
                $display("FAIL midwait_no_grant c%0d: got %b expected %b", c, ifGrant, 1'b0);
            end
            next_cycle();
        end
        ifReq = 1'b1;
        ifAddr = 32'h44;
        for (int c = 0; c <= 4; c++) begin
            #1;
            n_checks++;
            if (ifGrant !== (c == 4)) begin
                n_fail++;
                $display("FAIL midwait_refetch_grant c%0d: got %b expected %b", c, ifGrant, (c == 4));
            end
            if (c == 4) begin
                n_checks++;
                if (ifData !== 32'h33334444) begin
                    n_fail++;
                    $display("FAIL midwait_refetch_data: got %h expected %h", ifData, 32'h33334444);
                end
            end
            next_cycle();
        end
        ifReq = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8C220004;
        mem[16] = 32'h11112222;
        mem[17] = 32'h33334444;
        repeat (2) @(posedge clk);
        test_reset_state();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        test_single_fetch();
        test_contention();
        test_starvation();
        next_cycle();
        test_store();
        test_reset();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
